// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : Requester and memory-bus signal bundle for mem_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        wr;
    logic [NUM_CH*ADDR_W-1:0] addr;
    logic [NUM_CH*DATA_W-1:0] wdata;
    logic                     hold;
    logic [NUM_CH-1:0]        gnt;
    logic [NUM_CH-1:0]        done;
    logic [DATA_W-1:0]        rdata;
    logic [ADDR_W-1:0]        busAddr;
    logic                     busWr;
    logic [DATA_W-1:0]        busWdata;
    logic                     busDataOe;
    logic                     busRamEn;
    logic                     busMapEn;
    logic [DATA_W-1:0]        busRdata;

    // The arbiter serves the requesters, so it takes the slave view.
    modport slave (
        input  req, wr, addr, wdata, hold, busRdata,
        output gnt, done, rdata, busAddr, busWr, busWdata, busDataOe, busRamEn, busMapEn
    );

    modport master (
        output req, wr, addr, wdata, hold, busRdata,
        input  gnt, done, rdata, busAddr, busWr, busWdata, busDataOe, busRamEn, busMapEn
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Multi-channel memory bus arbiter with wait states and RAM /
//               mapped-peripheral decode. Define MEM_ARB_RR_EN for
//               round-robin arbitration (fixed priority otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int                NUM_CH   = 3,
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                WAIT_CYC = 1,
    parameter logic [ADDR_W-1:0] MAP_BASE = 16'hF000
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    mem_bus_arbiter_if.slave bus
);
    localparam int                  c_IDX_W     = $clog2(NUM_CH);
    localparam int                  c_WAIT_W    = 4;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(WAIT_CYC);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_ACCESS  = 2'd1;
    localparam logic [1:0] c_S_RELEASE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_nextState;
    logic                r_armed;
    logic [NUM_CH-1:0]   r_gnt;
    logic [NUM_CH-1:0]   w_grantVec;
    logic                w_found;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_selAddr;
    logic                r_wr;
    logic                w_selWr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   w_selWdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [c_WAIT_W-1:0] r_wait;
    logic                w_start;
    logic                w_lastAccess;
    logic                w_inAccess;
    logic                w_isMap;

    // r_armed keeps the first post-reset edge grant-free.
    assign w_start      = (r_state == c_S_IDLE) && r_armed && !bus.hold && (|bus.req);
    assign w_lastAccess = (r_state == c_S_ACCESS) && (r_wait == '0);

`ifdef MEM_ARB_RR_EN
    logic [c_IDX_W-1:0] r_ptr;
    logic [c_IDX_W-1:0] w_ptrNext;

    always_comb begin
        int k;
        k          = 0;
        w_grantVec = '0;
        w_found    = 1'b0;
        w_ptrNext  = r_ptr;
        for (int j = 0; j < NUM_CH; j++) begin
            k = int'(r_ptr) + j;
            if (k >= NUM_CH) k = k - NUM_CH;
            if (!w_found && bus.req[c_IDX_W'(k)]) begin
                w_found                     = 1'b1;
                w_grantVec[c_IDX_W'(k)]     = 1'b1;
                w_ptrNext                   = (k == NUM_CH - 1) ? '0 : c_IDX_W'(k + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        r_ptr <= '0;
        else if (w_start) r_ptr <= w_ptrNext;
    end
`else
    always_comb begin
        w_grantVec = '0;
        w_found    = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!w_found && bus.req[j]) begin
                w_found       = 1'b1;
                w_grantVec[j] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_selAddr  = '0;
        w_selWr    = 1'b0;
        w_selWdata = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (w_grantVec[j]) begin
                w_selAddr  = bus.addr[j*ADDR_W +: ADDR_W];
                w_selWr    = bus.wr[j];
                w_selWdata = bus.wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= c_S_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_S_IDLE:    if (w_start) w_nextState = c_S_ACCESS;
            c_S_ACCESS:  if (r_wait == '0) w_nextState = c_S_RELEASE;
            c_S_RELEASE: w_nextState = c_S_IDLE;
            default:     w_nextState = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_armed <= 1'b0;
            r_gnt   <= '0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_wait  <= '0;
            r_rdata <= '0;
        end else begin
            r_armed <= 1'b1;
            if (w_start) begin
                r_gnt   <= w_grantVec;
                r_addr  <= w_selAddr;
                r_wr    <= w_selWr;
                r_wdata <= w_selWdata;
                r_wait  <= c_WAIT_LOAD;
            end else if ((r_state == c_S_ACCESS) && (r_wait != '0)) begin
                r_wait <= r_wait - c_WAIT_W'(1);
            end else if (r_state == c_S_RELEASE) begin
                r_gnt <= '0;
            end
            if (w_lastAccess && !r_wr) r_rdata <= bus.busRdata;
        end
    end

    assign w_inAccess = (r_state == c_S_ACCESS);
    assign w_isMap    = (r_addr >= MAP_BASE);

    always_comb begin
        bus.gnt       = r_gnt;
        bus.done      = (r_state == c_S_RELEASE) ? r_gnt : '0;
        bus.rdata     = r_rdata;
        bus.busAddr   = r_addr;
        bus.busWdata  = r_wdata;
        bus.busWr     = w_inAccess & r_wr;
        bus.busDataOe = w_inAccess & r_wr;
        bus.busRamEn  = w_inAccess & !w_isMap;
        bus.busMapEn  = w_inAccess & w_isMap;
    end
endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of requesting channels, legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 16: address width.
REQ-003 SHALL have parameter DATA_W, default 16: data width.
REQ-004 SHALL have parameter WAIT_CYC, default 1: wait states per access, legal range 0..15.
REQ-005 SHALL have parameter MAP_BASE, default 16'hF000: first address routed to mapped peripherals.
REQ-006 SHALL have ports: clk  input  1  single clock, rising edge.
REQ-007 SHALL have ports: rstn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports: req  input  NUM_CH  per-channel access request.
REQ-009 SHALL have ports: wr  input  NUM_CH  per-channel write (1) / read (0).
REQ-010 SHALL have ports: addr  input  NUM_CH*ADDR_W  per-channel address; channel i at bits [i*ADDR_W +: ADDR_W].
REQ-011 SHALL have ports: wdata  input  NUM_CH*DATA_W  per-channel write data, packed as addr.
REQ-012 SHALL have ports: hold  input  1  blocks new grants when high (pause).
REQ-013 SHALL have ports: gnt  output  NUM_CH  one-hot grant, held for the whole access.
REQ-014 SHALL have ports: done  output  NUM_CH  one-cycle completion pulse to the granted channel.
REQ-015 SHALL have ports: rdata  output  DATA_W  captured read data.
REQ-016 SHALL have ports: busAddr  output  ADDR_W; busWr  output  1; busWdata  output  DATA_W; busDataOe  output  1; busRamEn  output  1; busMapEn  output  1; busRdata  input  DATA_W.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RELEASE.
REQ-018 IDLE: if hold=0 and any req=1, SHALL register the winner's addr/wr/wdata, set gnt one-hot, load the wait counter with WAIT_CYC, and enter ACCESS on the next edge.
REQ-019 IDLE with hold=1 SHALL stay in IDLE, keep gnt=0, and leave pending requests unserviced.
REQ-020 ACCESS: SHALL drive busAddr/busWr/busWdata from the registered values, with busDataOe=busWr and exactly one of busRamEn/busMapEn high.
REQ-021 ACCESS SHALL last WAIT_CYC+1 cycles; on its last cycle busRdata SHALL be captured into rdata for reads.
REQ-022 rdata SHALL be unchanged by writes and hold its value until the next read capture.
REQ-023 RELEASE: all bus enables and busDataOe SHALL be low (turnaround); done[winner]=1 for that cycle only; gnt is cleared at the end of RELEASE; next state IDLE.
REQ-024 Latency: req sampled at edge k gives gnt at k+1 and done at k+WAIT_CYC+2; back-to-back accesses are spaced WAIT_CYC+3 cycles apart.
REQ-025 busMapEn SHALL be high when the registered address >= MAP_BASE; otherwise busRamEn; unsigned compare at ADDR_W.
REQ-026 A requester SHALL hold addr/wr/wdata stable until done; the arbiter ignores changes after the grant (registered copy).
REQ-027 Dropping req during ACCESS SHALL NOT abort the access; it completes and done still pulses.
REQ-028 req still high in the done cycle SHALL be treated as a new request in the following IDLE.
REQ-029 hold rising during ACCESS/RELEASE SHALL NOT abort the access; it takes effect in IDLE.
REQ-030 Without the REQ-036 feature, fixed priority SHALL apply: the lowest-index active req wins.

Reset
REQ-031 rstn=0 SHALL immediately force state IDLE, gnt=0, done=0, rdata=0, busAddr=0, busWr=0, busWdata=0, busDataOe=0, busRamEn=0, busMapEn=0, and wait counter=0.
REQ-032 The round-robin pointer SHALL reset to 0.
REQ-033 Reset mid-access SHALL abandon the access with no done pulse.
REQ-034 After rstn deasserts, the first grant SHALL occur no earlier than the second rising edge.

Configuration
REQ-035 SHALL recognise the macro MEM_ARB_RR_EN.
REQ-036 With MEM_ARB_RR_EN defined, SHALL use round-robin arbitration: search starts at the pointer, and the pointer becomes (winner+1) mod NUM_CH at each grant.
REQ-037 Without MEM_ARB_RR_EN, SHALL use fixed priority (REQ-030) and omit the pointer logic.

Verification
REQ-038 WAIT_CYC=1; ch1 read of 0x0010 with busRdata=0xBEEF -> gnt=3'b010 at k+1; busRamEn high for 2 cycles; done[1] at k+3; rdata=0xBEEF.
REQ-039 Ch0 write of 0xF004 with data 0x1234 -> busMapEn=1, busRamEn=0, busDataOe=1, busWdata=0x1234; rdata unchanged.
REQ-040 req=3'b111 held, fixed priority -> grants 0,0,0...; with MEM_ARB_RR_EN -> grants 0,1,2,0 at spacing WAIT_CYC+3.
REQ-041 hold=1 with req=3'b100 -> gnt stays 0; hold drops -> gnt=3'b100 on the next edge.
REQ-042 rstn pulled low in the ACCESS cycle -> all outputs 0 immediately, no done pulse; after release, the pending req is re-granted.
REQ-043 WAIT_CYC=0 with req dropped one cycle after grant -> access completes, done pulses at k+2.
